param_load_controller: RTL and testbench
========================================

# param_load_controller

Sequences the serial load of the 24-byte neuron parameter shift register: 4 neurons × (4 weights, bias, threshold). It accepts parameter bytes from an upstream byte source over a valid/ready handshake and forwards each byte with a one-cycle shift command. It counts exactly NUM_PARAMS shifts, flags completion once the shift register holds the final values, and aborts the load if the source stalls too long. It sits between the host byte interface (UART/SPI receiver) and the parameter shift register's data_in/selector inputs.

## Interface

- NUM_PARAMS, 24, bytes per complete load; legal range 1..31.
- TIMEOUT, 1023, maximum idle cycles between accepted bytes while loading; legal range 1..1023.

- clk  input  1  single system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- start  input  1  request a new load; level-sampled.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream parameter byte; first byte is w00, last byte is th3.
- in_ready  output  1  controller can accept a byte.
- sr_data  output  8  byte to the shift register data_in.
- sr_selector  output  2  shift register command: 2'b01 = shift, 2'b00 = hold.
- busy  output  1  load in progress.
- loaded  output  1  complete parameter set present in the shift register.
- err  output  1  last load aborted by timeout.
- byte_count  output  5  bytes accepted in the current load.

## Operation

- States: IDLE, LOAD, DONE, ERR.
- Reset (any state, including mid-load), all registered, next edge:
  - state = IDLE
  - sr_selector = 2'b00, sr_data = 0
  - byte_count = 0, idle counter = 0
  - busy = 0, loaded = 0, err = 0
- IDLE / DONE / ERR with start = 1 → LOAD:
  - byte_count and idle counter cleared
  - loaded and err cleared
  - busy set
- LOAD with start = 1: start is ignored and the load continues.
- in_ready = (state == LOAD), combinational from state only.
- A transfer occurs on an edge where in_valid & in_ready. On that edge:
  - sr_data <= in_data
  - sr_selector <= 2'b01
  - byte_count increments
  - idle counter clears
- sr_selector:
  - is 2'b01 for exactly one cycle per transfer and 2'b00 otherwise
  - never emits 2'b10 or 2'b11
  - back-to-back transfers give a continuous 2'b01 run
- Final transfer (byte_count == NUM_PARAMS-1 at the transfer edge) → DONE. in_ready drops the cycle after the final transfer.
- loaded is set on the edge after the final transfer, when the shift register captures th3. busy clears on that same edge.
- In LOAD with no transfer, the idle counter increments. When it reaches TIMEOUT → ERR:
  - err = 1, busy = 0, loaded = 0
  - sr_selector = 2'b00
  - byte_count holds its value for debug
- While not in LOAD, in_valid is ignored and no shift is issued.
- The shift register's own reset is driven by the same reset. A partial load is never flagged loaded. Any new load shifts in all NUM_PARAMS bytes, overwriting all stale contents.

## Timing

- Latency from transfer edge to shift register capture: 1 cycle (sr_data and sr_selector are registered together).
- Throughput: 1 byte per cycle with in_valid held high. A full 24-byte load finishes at edge N+24, where N is the edge on which start is sampled. A zero-wait source streams the first byte at edge N+1 and the last at edge N+24; loaded is high from edge N+25.
- Timeout fires on the edge where the idle counter would exceed TIMEOUT-1, i.e. TIMEOUT cycles after the last transfer edge (or after LOAD entry).
- in_valid and timeout expiring in the same cycle: the transfer wins, the idle counter clears, and the state stays LOAD.
- Reset asserted on the same edge as a transfer: reset wins, no shift issued, sr_selector = 2'b00.

## Test plan

- Reset mid-load:
  - Stimulus: reset after 10 bytes.
  - Required response: next cycle sr_selector = 2'b00, byte_count = 0, busy = 0, loaded = 0, in_ready = 0.
- Full streamed load:
  - Stimulus: start, then bytes 0x01..0x18 streamed with in_valid held high.
  - Required response: 24 consecutive cycles of sr_selector = 2'b01. loaded rises one cycle after the 24th transfer. The shift register reads w00 = 0x01, th0 = 0x06, w30 = 0x13, th3 = 0x18.
- Gapped load:
  - Stimulus: bytes with random 0–5 cycle gaps.
  - Required response: exactly 24 shift pulses, byte_count = 24 in DONE, and shift register contents identical to the streamed case.
- Timeout:
  - Stimulus: TIMEOUT = 8; stop after 5 bytes.
  - Required response: ERR 8 cycles after the 5th transfer edge, err = 1, loaded = 0, byte_count = 5, in_ready = 0. A subsequent start clears err and a complete load succeeds.
- start during LOAD and extra bytes in DONE:
  - Stimulus: start held high throughout, and in_valid still high after byte 24.
  - Required response: no restart, no 25th shift. in_ready = 0 and loaded = 1 remain.
- Back-to-back reload:
  - Stimulus: start while in DONE.
  - Required response: loaded clears on the next edge, and 24 new bytes fully replace the previous set.

Source files
------------

// File: rtl/param_load_controller.sv
// Load sequencer for the 24-byte neuron parameter shift register: accepts bytes over
// valid/ready, issues one registered shift per byte, and flags completion or idle timeout.
module param_load_controller #(
  parameter int NUM_PARAMS = 24,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] sr_data,
  output logic [1:0] sr_selector,
  output logic       busy,
  output logic       loaded,
  output logic       err,
  output logic [4:0] byte_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_PARAMS - 1);
  localparam logic [9:0] IDLE_MAX = 10'(TIMEOUT - 1);

  state_t     state_reg;
  logic [9:0] idle_cnt_reg;
  logic       xfer;

  assign in_ready = (state_reg == LOAD);
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      sr_selector  <= 2'b00;
      sr_data      <= 8'h00;
      byte_count   <= 5'd0;
      idle_cnt_reg <= 10'd0;
      busy         <= 1'b0;
      loaded       <= 1'b0;
      err          <= 1'b0;
    end else begin
      // Shift command is a single-cycle pulse unless a transfer re-arms it below.
      sr_selector <= 2'b00;
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_reg    <= LOAD;
            byte_count   <= 5'd0;
            idle_cnt_reg <= 10'd0;
            loaded       <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b1;
          end else if (state_reg == DONE) begin
            // First DONE cycle is when the shift register has captured the last byte.
            loaded <= 1'b1;
            busy   <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            sr_data      <= in_data;
            sr_selector  <= 2'b01;
            byte_count   <= byte_count + 5'd1;
            idle_cnt_reg <= 10'd0;
            if (byte_count == LAST_IDX) begin
              state_reg <= DONE;
            end
          end else if (idle_cnt_reg == IDLE_MAX) begin
            state_reg <= ERR;
            err       <= 1'b1;
            busy      <= 1'b0;
            loaded    <= 1'b0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 10'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_load_controller.sv
// Directed bench for param_load_controller with a behavioural 24-byte shift register.
module tb_param_load_controller;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, busy, loaded, err;
  logic [7:0] sr_data;
  logic [1:0] sr_selector;
  logic [4:0] byte_count;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int illegal_sel = 0;
  int p0;

  logic [7:0] sr [24];

  param_load_controller #(.NUM_PARAMS(24), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sr_data(sr_data), .sr_selector(sr_selector), .busy(busy),
    .loaded(loaded), .err(err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Parameter shift register: after a full load, sr[k] holds the k-th byte sent.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 24; k++) sr[k] <= 8'h00;
    end else if (sr_selector == 2'b01) begin
      for (int k = 0; k < 23; k++) sr[k] <= sr[k+1];
      sr[23] <= sr_data;
    end
  end

  always @(posedge clk) begin
    if (sr_selector == 2'b01) pulses++;
    if (sr_selector[1] === 1'b1) illegal_sel++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams n bytes base+1..base+n with in_valid held high; checks each transfer.
  task automatic stream(input int n, input logic [7:0] base, input int cnt0);
    in_valid = 1'b1;
    for (int i = 1; i <= n; i++) begin
      in_data = base + 8'(i);
      tick();
      check($sformatf("sel_b%0d", i), 32'(sr_selector), 32'h1);
      check($sformatf("data_b%0d", i), 32'(sr_data), 32'(base + 8'(i)));
      check($sformatf("cnt_b%0d", i), 32'(byte_count), 32'(cnt0 + i));
    end
  endtask

  task automatic check_sr(input string tag, input logic [7:0] base);
    for (int k = 0; k < 24; k++)
      check($sformatf("%s_sr%0d", tag, k), 32'(sr[k]), 32'(base + 8'(k + 1)));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_loaded", 32'(loaded), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(byte_count), 0);
    check("rst_sel", 32'(sr_selector), 0);
    check("rst_data", 32'(sr_data), 0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(in_ready), 0);

    // Streamed load with start held high throughout LOAD
    start = 1'b1;
    tick();
    p0 = pulses;
    check("ld_busy", 32'(busy), 1);
    check("ld_ready", 32'(in_ready), 1);
    stream(24, 8'h00, 0);
    check("done_ready", 32'(in_ready), 0);
    check("done_loaded_early", 32'(loaded), 0);
    start = 1'b0;
    tick();
    check("done_loaded", 32'(loaded), 1);
    check("done_busy", 32'(busy), 0);
    check("done_sel", 32'(sr_selector), 0);
    check("w00", 32'(sr[0]), 32'h01);
    check("th0", 32'(sr[5]), 32'h06);
    check("w30", 32'(sr[18]), 32'h13);
    check("th3", 32'(sr[23]), 32'h18);
    // Extra bytes offered in DONE must be ignored
    in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("extra_ready", 32'(in_ready), 0);
      check("extra_loaded", 32'(loaded), 1);
      check("extra_sel", 32'(sr_selector), 0);
    end
    check("stream_pulses", 32'(pulses - p0), 24);
    check("extra_cnt", 32'(byte_count), 24);

    // Back-to-back reload from DONE
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    p0 = pulses;
    check("reload_loaded", 32'(loaded), 0);
    check("reload_busy", 32'(busy), 1);
    check("reload_cnt", 32'(byte_count), 0);
    stream(24, 8'h80, 0);
    in_valid = 1'b0;
    tick();
    check("reload_done", 32'(loaded), 1);
    check("reload_pulses", 32'(pulses - p0), 24);
    check_sr("reload", 8'h80);

    // Gapped load with random 0..5 cycle gaps
    start = 1'b1;
    tick();
    start = 1'b0;
    p0 = pulses;
    for (int i = 1; i <= 24; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 5)) tick();
      in_valid = 1'b1;
      in_data = 8'(i);
      tick();
      check($sformatf("gap_cnt%0d", i), 32'(byte_count), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("gap_loaded", 32'(loaded), 1);
    check("gap_cnt_done", 32'(byte_count), 24);
    check("gap_pulses", 32'(pulses - p0), 24);
    check_sr("gap", 8'h00);

    // Timeout after 5 bytes (TIMEOUT = 8)
    start = 1'b1;
    tick();
    start = 1'b0;
    p0 = pulses;
    stream(5, 8'h40, 0);
    in_valid = 1'b0;
    repeat (7) tick();
    check("to_pre_err", 32'(err), 0);
    check("to_pre_ready", 32'(in_ready), 1);
    tick();
    check("to_err", 32'(err), 1);
    check("to_loaded", 32'(loaded), 0);
    check("to_busy", 32'(busy), 0);
    check("to_cnt", 32'(byte_count), 5);
    check("to_ready", 32'(in_ready), 0);
    check("to_pulses", 32'(pulses - p0), 5);

    // Recovery; first byte lands on the edge the timeout would fire
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rec_err", 32'(err), 0);
    check("rec_busy", 32'(busy), 1);
    repeat (7) tick();
    stream(24, 8'h20, 0);
    in_valid = 1'b0;
    tick();
    check("rec_loaded", 32'(loaded), 1);
    check("rec_err_final", 32'(err), 0);
    check_sr("rec", 8'h20);

    // Reset mid-load, coinciding with an offered byte
    start = 1'b1;
    tick();
    start = 1'b0;
    stream(10, 8'h60, 0);
    reset = 1'b1;
    in_data = 8'h77;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("mrst_sel", 32'(sr_selector), 0);
    check("mrst_cnt", 32'(byte_count), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_loaded", 32'(loaded), 0);
    check("mrst_ready", 32'(in_ready), 0);
    tick();
    check("mrst_idle_ready", 32'(in_ready), 0);
    check("illegal_sel", 32'(illegal_sel), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
